// File: rtl/clock_meter_if.sv
// Purpose: bundle for clock_meter: the measured clock going in and the
//          measurement results coming out.
//   sig_i    : measured clock, asynchronous to the system clock
//   period_o : last measured period of sig_i, in system clock cycles
//   high_o   : last measured high time of sig_i, in system clock cycles
//   valid_o  : one-cycle pulse when period_o/high_o update
//   lost_o   : level, no rising edge on sig_i for TIMEOUT cycles
// The slave modport is taken by the meter, master by whoever drives sig_i
// and consumes the results.
interface clock_meter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             sig_i;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             lost_o;

  modport master (output sig_i, input  period_o, high_o, valid_o, lost_o);
  modport slave  (input  sig_i, output period_o, high_o, valid_o, lost_o);
endinterface

// File: rtl/clock_meter.sv
// Purpose: measures period and high time of an asynchronous clock sig_i in
//          clk_i cycles, and flags loss of sig_i after TIMEOUT cycles
//          without a rising edge.
// Ports:
//   clk_i : system clock, all state changes on its rising edge
//   rst_i : asynchronous active-high reset
//   bus   : clock_meter_if.slave (sig_i in; period_o, high_o, valid_o,
//           lost_o out, all registered)
module clock_meter #(
  parameter real         CLOCK_SYS = 100e6,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  clock_meter_if.slave bus
);

  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned EXT_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // CLOCK_SYS only documents the clk_i rate; reject nonsensical settings.
  if (CLOCK_SYS <= 0.0 || TIMEOUT < 2) begin : g_bad_param
    $error("clock_meter: CLOCK_SYS must be positive and TIMEOUT at least 2");
  end

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync_meta;
  logic             r_sync;
  logic             r_sync_d;
  logic             r_rise;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_lost;

  logic [CNT_W-1:0] w_per_nxt;
  logic [CNT_W-1:0] w_hi_nxt;
  logic [TO_W-1:0]  w_to_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic [CNT_W-1:0] w_high_nxt;
  logic             w_valid_nxt;
  logic             w_lost_nxt;
  logic [EXT_W-1:0] w_per_inc;
  logic             w_timeout;

  // Separate timeout counter so loss is still detected when per_cnt is
  // saturated (CNT_W narrower than TIMEOUT).
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Synchronizer, edge detector and all FSM/datapath state.
  // r_rise and r_sync_d describe the same synchronized sample, so the FSM
  // counts high time on exactly the samples it measures period on.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
      r_sync_d    <= 1'b0;
      r_rise      <= 1'b0;
      r_state     <= S_IDLE;
      r_per_cnt   <= '0;
      r_hi_cnt    <= '0;
      r_to_cnt    <= '0;
      r_period    <= '0;
      r_high      <= '0;
      r_valid     <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_sync_meta <= bus.sig_i;
      r_sync      <= r_sync_meta;
      r_sync_d    <= r_sync;
      r_rise      <= r_sync & ~r_sync_d;
      r_state     <= w_state_nxt;
      r_per_cnt   <= w_per_nxt;
      r_hi_cnt    <= w_hi_nxt;
      r_to_cnt    <= w_to_nxt;
      r_period    <= w_period_nxt;
      r_high      <= w_high_nxt;
      r_valid     <= w_valid_nxt;
      r_lost      <= w_lost_nxt;
    end
  end

  // Next state: a rise always wins over a coinciding timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (r_rise) w_state_nxt = S_MEASURE;
      S_MEASURE: if (!r_rise && w_timeout) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Counter and result updates.
  always_comb begin
    w_per_nxt    = r_per_cnt;
    w_hi_nxt     = r_hi_cnt;
    w_to_nxt     = r_to_cnt;
    w_period_nxt = r_period;
    w_high_nxt   = r_high;
    w_valid_nxt  = 1'b0;
    w_lost_nxt   = r_lost;
    w_per_inc    = {1'b0, r_per_cnt} + EXT_W'(1);
    case (r_state)
      S_IDLE: begin
        if (r_rise) begin
          w_per_nxt  = '0;
          w_hi_nxt   = CNT_W'(1);
          w_to_nxt   = '0;
          w_lost_nxt = 1'b0;
        end
      end
      S_MEASURE: begin
        if (r_rise) begin
          // per_cnt+1 can carry out of a saturated counter; clamp it too.
          w_period_nxt = w_per_inc[CNT_W] ? CNT_MAX : w_per_inc[CNT_W-1:0];
          w_high_nxt   = r_hi_cnt;
          w_valid_nxt  = 1'b1;
          w_per_nxt    = '0;
          w_hi_nxt     = CNT_W'(1);
          w_to_nxt     = '0;
        end else begin
          if (r_per_cnt != CNT_MAX) w_per_nxt = r_per_cnt + CNT_W'(1);
          if (r_sync_d && (r_hi_cnt != CNT_MAX)) w_hi_nxt = r_hi_cnt + CNT_W'(1);
          w_to_nxt = r_to_cnt + TO_W'(1);
          if (w_timeout) begin
            w_lost_nxt = 1'b1;
            w_to_nxt   = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.period_o = r_period;
  assign bus.high_o   = r_high;
  assign bus.valid_o  = r_valid;
  assign bus.lost_o   = r_lost;

endmodule
